cam_ctrl: RTL and testbench
===========================

Name: cam_ctrl

Overview:
- Sequenced CAM table controller: owns a DEPTH-entry key table with per-entry valid bits.
- Arbitrates between a write/delete requester and a search requester.
- Each search is an iterative scan, LANES entries compared per cycle, so the comparator is no longer a full-depth combinational loop.
- Sits between packet/lookup logic and the key store; returns lowest matching address plus hit flag over a valid/ready response channel.

Parameters:
- DATA_WIDTH, 8, key width in bits
- ADDR_WIDTH, 4, entry address width
- DEPTH, 1<<ADDR_WIDTH, number of entries (derived, not overridden)
- LANES, 4, entries compared per scan cycle; power of two, divides DEPTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset
- wr_valid  input  1  write/delete request
- wr_ready  output  1  write accepted this cycle
- wr_del  input  1  1 = invalidate entry, 0 = write key and set valid
- wr_addr  input  ADDR_WIDTH  target entry
- wr_data  input  DATA_WIDTH  key to store (ignored when wr_del=1)
- srch_valid  input  1  search request
- srch_ready  output  1  search accepted this cycle
- srch_data  input  DATA_WIDTH  search key
- rsp_valid  output  1  search result available
- rsp_ready  input  1  result consumed
- rsp_hit  output  1  1 = match found
- rsp_addr  output  ADDR_WIDTH  lowest matching valid entry; 0 on miss
- busy  output  1  state != IDLE

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, all valid bits 0, rsp_valid=0, rsp_hit=0, rsp_addr=0, busy=0, rr_pri=0 (search favoured first). Key storage contents are not reset.
- Ready signals are combinational. Both ready signals are 0 outside IDLE.
- IDLE arbitration:
  - Only one of wr_valid/srch_valid high: that requester gets ready=1.
  - Both high: grant the requester favoured by rr_pri, then toggle rr_pri to favour the other.
  - Single-requester grants do not change rr_pri.
  - At most one ready is high per cycle.
- Write or delete: completes on the accepting edge and stays in IDLE.
  - wr_del=0: key[wr_addr]<=wr_data, valid[wr_addr]<=1.
  - wr_del=1: valid[wr_addr]<=0.
- Search accept: on the accepting edge, latch srch_data into key_q, group counter grp<=0, state<=SCAN.
- SCAN: each cycle compare key_q against entries grp*LANES .. grp*LANES+LANES-1.
  - An entry matches only if its valid bit is 1 and its key equals key_q.
  - Lowest matching index in the group wins.
  - Any match: register rsp_hit=1, rsp_addr=index, go to RESP.
  - No match and grp = DEPTH/LANES-1: rsp_hit=0, rsp_addr=0, go to RESP.
  - Otherwise grp<=grp+1.
- Latency: accept edge E0.
  - Hit in group g: rsp_valid=1 after edge E(g+1).
  - Miss: rsp_valid=1 after edge E(DEPTH/LANES).
  - Defaults: 1 to 4 cycles.
- RESP: rsp_valid=1; rsp_hit and rsp_addr hold stable until rsp_ready=1.
  - Handshake edge: rsp_valid<=0, state<=IDLE.
  - New requests are arbitrated from the next cycle, so back-to-back searches are spaced by at least one IDLE cycle.
- Table is frozen during SCAN/RESP because writes are only accepted in IDLE. A result always reflects the table state at search acceptance.
- Duplicate keys: lowest address wins across the whole table, because groups are scanned in ascending order.
- Reset asserted mid-SCAN or mid-RESP: immediate return to reset values. The pending search is dropped and no response is issued.

Optional Feature:
- Macro CAM_CTRL_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - In IDLE, flush=1 has top priority: both ready signals forced 0, all valid bits cleared on that edge, rr_pri unchanged.
  - flush outside IDLE is ignored and not queued.
- When undefined: no flush port; valid bits change only via wr_del or reset.

Test Plan:
- Reset, then search key 0x5A -> rsp_valid after 4 edges, rsp_hit=0, rsp_addr=0; busy high from the accept edge until the rsp handshake.
- Write 0x5A to addr 9 and 0x5A to addr 13, then search 0x5A -> rsp_hit=1, rsp_addr=9, rsp_valid after 3 edges (group 2).
- Write 0x33 to addr 1, search 0x33 -> rsp_hit=1, rsp_addr=1 after 1 edge. Then delete addr 1, search 0x33 -> rsp_hit=0.
- Hold wr_valid and srch_valid high together from reset -> search granted first, then write granted in the next IDLE; when both are requested again, search is granted again, confirming alternation.
- Hold rsp_ready=0 for 5 cycles after a hit at addr 6 -> rsp_valid, rsp_hit, rsp_addr stable; wr_ready=0 throughout even with wr_valid=1.
- Assert rst_n=0 during SCAN -> rsp_valid stays 0, all entries invalid; a subsequent search of a previously written key returns rsp_hit=0. With CAM_CTRL_FLUSH_EN: flush in IDLE, then search a written key -> rsp_hit=0.

Source files
------------

// File: rtl/cam_ctrl.sv
// Sequenced CAM table controller: write/delete and search arbitration with an iterative scan.
// Optional macro CAM_CTRL_FLUSH_EN adds a flush input that clears every valid bit while idle.
module cam_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_del,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  srch_valid,
  output logic                  srch_ready,
  input  logic [DATA_WIDTH-1:0] srch_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
`ifdef CAM_CTRL_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned GROUPS = DEPTH / LANES;
  localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e                state;
  logic                  rr_pri;
  logic [DATA_WIDTH-1:0] key_q;
  logic [GRP_W-1:0]      grp;
  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] keys [DEPTH];

  logic                  flush_req;
  logic [LANES-1:0]      lane_match;
  logic [ADDR_WIDTH-1:0] lane_idx [LANES];
  logic                  scan_hit;
  logic [ADDR_WIDTH-1:0] scan_addr;

`ifdef CAM_CTRL_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign busy = (state != StIdle);

  // rr_pri = 0 favours search, 1 favours write; only consulted when both request
  always_comb begin
    wr_ready   = 1'b0;
    srch_ready = 1'b0;
    if (state == StIdle && !flush_req) begin
      if (wr_valid && srch_valid) begin
        wr_ready   = rr_pri;
        srch_ready = !rr_pri;
      end else begin
        wr_ready   = wr_valid;
        srch_ready = srch_valid;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l]   = ADDR_WIDTH'(grp * LANES + l);
      lane_match[l] = valid[lane_idx[l]] && (keys[lane_idx[l]] == key_q);
    end
  end

  // Descending walk so the lowest matching lane is the last assignment
  always_comb begin
    scan_hit  = 1'b0;
    scan_addr = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_match[l]) begin
        scan_hit  = 1'b1;
        scan_addr = lane_idx[l];
      end
    end
  end

  // Key storage is intentionally left unreset; valid bits gate every match
  always_ff @(posedge clk) begin
    if (wr_ready && !wr_del) begin
      keys[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      valid     <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_addr  <= '0;
      rr_pri    <= 1'b0;
      key_q     <= '0;
      grp       <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (flush_req) begin
            valid <= '0;
          end else if (wr_ready) begin
            valid[wr_addr] <= !wr_del;
          end else if (srch_ready) begin
            key_q <= srch_data;
            grp   <= '0;
            state <= StScan;
          end
          if (wr_valid && srch_valid && !flush_req) begin
            rr_pri <= !rr_pri;
          end
        end
        StScan: begin
          if (scan_hit) begin
            rsp_hit   <= 1'b1;
            rsp_addr  <= scan_addr;
            rsp_valid <= 1'b1;
            state     <= StResp;
          end else if (grp == GRP_LAST) begin
            rsp_hit   <= 1'b0;
            rsp_addr  <= '0;
            rsp_valid <= 1'b1;
            state     <= StResp;
          end else begin
            grp <= grp + GRP_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed self-checking bench for cam_ctrl: latency, lowest-address hit, arbitration, reset.
// Exercises the flush path when CAM_CTRL_FLUSH_EN is defined.
module tb_cam_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_del = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       srch_valid = 1'b0;
  logic       srch_ready;
  logic [7:0] srch_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_hit;
  logic [3:0] rsp_addr;
  logic       busy;
`ifdef CAM_CTRL_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cam_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .LANES     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_del    (wr_del),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .srch_valid(srch_valid),
    .srch_ready(srch_ready),
    .srch_data (srch_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_addr  (rsp_addr),
`ifdef CAM_CTRL_FLUSH_EN
    .flush     (flush),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset;
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_del     = 1'b0;
    srch_valid = 1'b0;
    rsp_ready  = 1'b0;
`ifdef CAM_CTRL_FLUSH_EN
    flush      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic del);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_del   = del;
    #1;
    n = 0;
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wr_grant", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_del   = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_search(input logic [7:0] k, input logic exp_hit,
                           input logic [3:0] exp_addr, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    srch_valid = 1'b1;
    srch_data  = k;
    #1;
    n = 0;
    while (!srch_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("srch_grant", srch_ready, 1);
    @(posedge clk);
    #1;
    srch_valid = 1'b0;
    check("busy_accept", busy, 1);
    wait_rsp(lat);
    check("rsp_latency", lat, exp_lat);
    check("rsp_hit", rsp_hit, exp_hit);
    check("rsp_addr", rsp_addr, exp_addr);
    check("busy_resp", busy, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("busy_done", busy, 0);
  endtask

  initial begin
    int n;
    int lat;

    apply_reset;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_hit", rsp_hit, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_srch_ready", srch_ready, 0);

    // Empty table: full miss scan over four groups
    do_search(8'h5A, 1'b0, 4'd0, 4);

    // Duplicates at 9 and 13: lowest wins, found in group 2
    do_write(4'd9, 8'h5A, 1'b0);
    do_write(4'd13, 8'h5A, 1'b0);
    do_search(8'h5A, 1'b1, 4'd9, 3);

    do_write(4'd1, 8'h33, 1'b0);
    do_search(8'h33, 1'b1, 4'd1, 1);
    do_write(4'd1, 8'h00, 1'b1);
    do_search(8'h33, 1'b0, 4'd0, 4);

    // Arbitration: search, then write, then search again with both held
    apply_reset;
    @(negedge clk);
    wr_valid   = 1'b1;
    wr_addr    = 4'd6;
    wr_data    = 8'h77;
    wr_del     = 1'b0;
    srch_valid = 1'b1;
    srch_data  = 8'h77;
    rsp_ready  = 1'b1;
    #1;
    check("arb1_srch", srch_ready, 1);
    check("arb1_wr", wr_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    n = 0;
    while (!(wr_ready || srch_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("arb2_wr", wr_ready, 1);
    check("arb2_srch", srch_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check("arb3_srch", srch_ready, 1);
    check("arb3_wr", wr_ready, 0);
    @(posedge clk);
    #1;
    srch_valid = 1'b0;
    rsp_ready  = 1'b0;
    wait_rsp(lat);
    check("arb3_latency", lat, 2);
    check("arb3_hit", rsp_hit, 1);
    check("arb3_addr", rsp_addr, 6);

    // Response held under backpressure; writes stay blocked
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_hit", rsp_hit, 1);
      check("hold_addr", rsp_addr, 6);
      check("hold_wr_ready", wr_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    wr_valid  = 1'b0;
    check("hold_release", rsp_valid, 0);

    // Reset mid-scan drops the search and clears the table
    @(negedge clk);
    srch_valid = 1'b1;
    srch_data  = 8'h77;
    #1;
    check("scan_rst_grant", srch_ready, 1);
    @(posedge clk);
    #1;
    srch_valid = 1'b0;
    @(posedge clk);
    #1;
    check("scan_rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("scan_rst_rsp_valid", rsp_valid, 0);
    check("scan_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("scan_rst_no_rsp", rsp_valid, 0);
    end
    do_search(8'h77, 1'b0, 4'd0, 4);

`ifdef CAM_CTRL_FLUSH_EN
    do_write(4'd3, 8'h44, 1'b0);
    do_search(8'h44, 1'b1, 4'd3, 1);
    @(negedge clk);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 4'd5;
    wr_data  = 8'h55;
    #1;
    check("flush_wr_ready", wr_ready, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    do_search(8'h44, 1'b0, 4'd0, 4);
    do_search(8'h55, 1'b0, 4'd0, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
